prbs_checker: RTL

//  Serial PRBS checker. Consumes the bit stream shifted out of a Fibonacci LFSR
//  (position N of a [1:N] register, new bit = Q[TAP_A]^Q[TAP_B] entering at position 1).

---
 rtl/prbs_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises on a Fibonacci LFSR bit stream, locks, counts mismatches.
// Latency: outputs registered, one cycle after the sampling edge of the bit that caused them.
// Backpressure: none; bit_valid qualifies each bit and idle cycles leave all state untouched.
//
// Ports:
//    clk        rising-edge clock
//    reset      asynchronous active-high reset
//    bit_valid  bit_in is sampled only when high
//    bit_in     received PRBS bit
//    clear_cnt  synchronous clear of err_count (wins over a same-cycle mismatch)
//    locked     checker is in LOCKED
//    err_pulse  one-cycle pulse per mismatch while locked
//    lock_lost  one-cycle pulse on the LOCKED -> VERIFY transition
//    err_count  saturating mismatch count, only incremented while locked
module prbs_checker #(
   parameter int N        = 3,
   parameter int TAP_A    = 2,
   parameter int TAP_B    = 3,
   parameter int LOCK_CNT = 8,
   parameter int WIN      = 64,
   parameter int LOSS_THR = 8,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          bit_valid,
   input  logic          bit_in,
   input  logic          clear_cnt,
   output logic          locked,
   output logic          err_pulse,
   output logic          lock_lost,
   output logic [CW-1:0] err_count
);

   localparam int FW = $clog2(N + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WIN);
   localparam int MW = $clog2(LOSS_THR + 1);

   // Terminal values are compared against the count *before* the current bit is
   // added, so each holds "target minus one".
   localparam logic [FW-1:0] FILL_END = FW'(N - 1);
   localparam logic [GW-1:0] GOOD_END = GW'(LOCK_CNT - 1);
   localparam logic [WW-1:0] WIN_END  = WW'(WIN - 1);
   localparam logic [MW-1:0] MISS_END = MW'(LOSS_THR - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t        state;
   logic [N:1]    h;       // received-bit history, h[1] newest
   logic [FW-1:0] fill;
   logic [GW-1:0] good;
   logic [WW-1:0] win;
   logic [MW-1:0] miss;

   logic pred;
   logic match;
   logic hist_zero;

   // Prediction uses the history before this bit is shifted in.
   assign pred      = h[TAP_A] ^ h[TAP_B];
   assign match     = (bit_in == pred);
   assign hist_zero = (h == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         h         <= '0;
         fill      <= '0;
         good      <= '0;
         win       <= '0;
         miss      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         lock_lost <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         lock_lost <= 1'b0;

         if (clear_cnt) begin
            err_count <= '0;
         end

         if (bit_valid) begin
            h <= {h[N-1:1], bit_in};

            case (state)
               SEARCH: begin
                  // Only fill the history; no comparisons until it holds N real bits.
                  if (fill == FILL_END) begin
                     state <= VERIFY;
                     good  <= '0;
                  end
                  fill <= fill + 1'b1;
               end

               VERIFY: begin
                  // The all-zero history is a fixed point of the LFSR and must never lock.
                  if (match && !hist_zero) begin
                     if (good == GOOD_END) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        good   <= '0;
                        win    <= '0;
                        miss   <= '0;
                     end else begin
                        good <= good + 1'b1;
                     end
                  end else begin
                     good <= '0;
                  end
               end

               LOCKED: begin
                  if (!match) begin
                     err_pulse <= 1'b1;
                     if (!clear_cnt && (err_count != {CW{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                     end
                     if (miss == MISS_END) begin
                        // Loss of lock takes precedence over the window wrap.
                        state     <= VERIFY;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                        good      <= '0;
                        win       <= '0;
                        miss      <= '0;
                     end else if (win == WIN_END) begin
                        win  <= '0;
                        miss <= '0;
                     end else begin
                        win  <= win + 1'b1;
                        miss <= miss + 1'b1;
                     end
                  end else begin
                     if (win == WIN_END) begin
                        win  <= '0;
                        miss <= '0;
                     end else begin
                        win <= win + 1'b1;
                     end
                  end
               end

               default: begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
